// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/subtract split into WIDTH/BLOCK pipeline
// stages. Each stage resolves one BLOCK-bit group with carry-lookahead, using
// the carry registered by the stage before it. The pipeline uses a
// valid/ready handshake and the whole pipeline freezes while the output is
// stalled.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTAGES = WIDTH / BLOCK;

  // Refuse to elaborate when the width cannot be split evenly into groups.
  if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_params
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic             stall;
  logic [WIDTH-1:0] y_eff;

  // Subtraction is A + ~B + 1, so the operand is inverted and the carry-in flipped.
  assign y_eff = in_sub ? ~in_y : in_y;

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    // Operand bits still waiting to be summed when they reach this stage.
    localparam int REM = WIDTH - k * BLOCK;

    logic             v_in;
    logic             c_in;
    logic             top_in;
    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic [WIDTH-1:0] sum_in;

    logic [BLOCK-1:0] gen;
    logic [BLOCK-1:0] prop;
    logic [BLOCK:0]   cy;
    logic [BLOCK-1:0] blk_sum;
    logic [WIDTH-1:0] sum_next;
    logic             top_next;

    logic             v_q;
    logic             c_q;
    logic             top_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_src
      assign v_in   = in_valid;
      assign a_in   = in_x;
      assign b_in   = y_eff;
      assign c_in   = in_cin ^ in_sub;
      assign sum_in = '0;
      assign top_in = 1'b0;
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_q;
      assign a_in   = g_stage[k-1].g_ops.a_q;
      assign b_in   = g_stage[k-1].g_ops.b_q;
      assign c_in   = g_stage[k-1].c_q;
      assign sum_in = g_stage[k-1].sum_q;
      assign top_in = g_stage[k-1].top_q;
    end

    // Group lookahead: every carry is a flat sum of products of g/p terms and the group carry-in.
    always_comb begin : p_cla
      logic acc;
      logic run;
      acc  = 1'b0;
      run  = 1'b0;
      gen  = a_in[BLOCK-1:0] & b_in[BLOCK-1:0];
      prop = a_in[BLOCK-1:0] ^ b_in[BLOCK-1:0];
      cy   = '0;
      cy[0] = c_in;
      for (int i = 0; i < BLOCK; i++) begin
        acc = gen[i];
        run = prop[i];
        for (int j = i - 1; j >= 0; j--) begin
          acc = acc | (run & gen[j]);
          run = run & prop[j];
        end
        cy[i+1] = acc | (run & c_in);
      end
      blk_sum  = prop ^ cy[BLOCK-1:0];
      sum_next = sum_in | (WIDTH'(blk_sum) << (k * BLOCK));
      top_next = (k == NSTAGES - 1) ? cy[BLOCK-1] : top_in;
    end

    // Stage register: advances only when the output is not stalled.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        top_q <= 1'b0;
        sum_q <= '0;
      end else if (!stall) begin
        v_q   <= v_in;
        c_q   <= cy[BLOCK];
        top_q <= top_next;
        sum_q <= sum_next;
      end
    end

    if (k < NSTAGES - 1) begin : g_ops
      logic [REM-BLOCK-1:0] a_q;
      logic [REM-BLOCK-1:0] b_q;

      // Carry the untouched high operand bits forward to the next group.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= a_in[REM-1:BLOCK];
          b_q <= b_in[REM-1:BLOCK];
        end
      end
    end
  end

  assign out_valid = g_stage[NSTAGES-1].v_q;
  assign out_sum   = g_stage[NSTAGES-1].sum_q;
  assign out_cout  = g_stage[NSTAGES-1].c_q;
  assign out_ovf   = g_stage[NSTAGES-1].top_q ^ g_stage[NSTAGES-1].c_q;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a positive multiple of BLOCK.
REQ-002 Parameter BLOCK, default 8: bits resolved per pipeline stage by one carry-lookahead group.
REQ-003 Derived NSTAGES = WIDTH/BLOCK; the compile SHALL fail if WIDTH mod BLOCK != 0.
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  operand set present.
REQ-007 in_ready  out  1  block can accept this cycle.
REQ-008 in_x  in  WIDTH  operand A.
REQ-009 in_y  in  WIDTH  operand B.
REQ-010 in_sub  in  1  0 = A+B+cin, 1 = A-B-borrow.
REQ-011 in_cin  in  1  carry-in (add) / borrow-in (sub).
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_sum  out  WIDTH  result.
REQ-015 out_cout  out  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 out_ovf  out  1  signed two's-complement overflow.

Function
REQ-017 Effective operands: B' = in_sub ? ~in_y : in_y; c0 = in_cin XOR in_sub.
REQ-018 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-019 Stage k (1..NSTAGES) SHALL compute sum bits [k*BLOCK-1:(k-1)*BLOCK] with generate/propagate lookahead from the carry registered by stage k-1; no ripple across a stage boundary within a cycle.
REQ-020 Each stage register SHALL hold: valid bit, completed low sum bits, carry into next block, unconsumed high operand bits, carry into current top bit (for overflow).
REQ-021 Latency: a transfer accepted at rising edge t with no stall SHALL present out_valid=1 with its result after edge t+NSTAGES-1 (i.e. NSTAGES cycles after acceptance, counting the accepting edge as 1).
REQ-022 Throughput: one operation per cycle sustained while out_ready=1.
REQ-023 Stall: stall = out_valid && !out_ready; while stall, all stage registers SHALL hold and in_ready SHALL be 0.
REQ-024 in_ready = !stall (combinational from out_valid and out_ready); bubbles SHALL advance only when not stalled.
REQ-025 out_sum/out_cout/out_ovf SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 out_cout = carry out of bit WIDTH-1; out_ovf = carry into bit WIDTH-1 XOR out_cout.
REQ-027 Results SHALL leave in acceptance order; no operation dropped or duplicated.
REQ-028 When in_valid=0 on a non-stalled cycle, a bubble (valid=0) SHALL enter stage 1.
REQ-029 NSTAGES=1 SHALL degenerate to a single registered lookahead adder with latency 1.

Reset
REQ-030 reset_n=0 SHALL asynchronously clear all stage valid bits; out_valid=0, out_sum=0, out_cout=0, out_ovf=0 while asserted.
REQ-031 in_ready SHALL be 1 during and after reset (pipeline empty, no stall).
REQ-032 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge after deassertion.
REQ-033 Deassertion is synchronised externally; first transfer accepted on the first rising edge with reset_n=1.

Verification (WIDTH=32, BLOCK=8)
REQ-034 Add 0x7FFFFFFF+0x00000001, sub=0, cin=0 -> 4 cycles later sum=0x80000000, cout=0, ovf=1.
REQ-035 Sub 0x00000000-0x00000001, cin=0 -> sum=0xFFFFFFFF, cout=0, ovf=0; sub 5-3 -> sum=2, cout=1, ovf=0.
REQ-036 Full carry chain 0xFFFFFFFF+0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0 (carry crosses all 4 stages).
REQ-037 Back-to-back 8 random ops with out_ready=1 -> 8 consecutive out_valid cycles, results match reference model in order.
REQ-038 Hold out_ready=0 for 6 cycles during a stream -> in_ready=0 while out_valid=1, outputs stable, no loss/duplication after release.
REQ-039 Assert reset_n=0 with 3 ops in flight -> out_valid=0 immediately, no stale result after deassertion, in_ready=1.
